// File: rtl/keccak_rho_inv.sv
// Multi-cycle inverse-rho unit for Keccak-f[1600]; rotates each lane right
// by its rho offset, LPC lanes per clock, result returned over valid/ready.
//
// Parameters: W (lane width), LPC (lanes per cycle: 1, 5 or 25).
// Ports: clk, rst_n (async, active-low), in_valid/in_ready/in_state
// (25*W input), out_valid/out_ready/out_state (25*W result), busy (RUN).
// Option macro KECCAK_RHO_DIR_SEL_EN adds input `dir`
// (1 = forward rho, 0 = inverse rho), sampled on the accept edge.
module keccak_rho_inv #(
    parameter int W   = 64,
    parameter int LPC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
`ifdef KECCAK_RHO_DIR_SEL_EN
    input  logic            dir,
`endif
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [25*W-1:0] in_state,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [25*W-1:0] out_state,
    output logic            busy
);

    localparam int RHO [25] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    localparam logic [4:0] STEP = 5'(LPC);
    localparam logic [4:0] K_LAST = 5'(25 - LPC);

    generate
        if (!(LPC == 1 || LPC == 5 || LPC == 25)) begin : g_bad_lpc
            $error("keccak_rho_inv: LPC must be 1, 5 or 25");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [25*W-1:0]   st;
    logic [4:0]        k;
    logic              xfer;
    logic              last;
    logic [24:0]       win;
    logic [W-1:0]      rot [25];
    logic              dir_q;

    assign xfer = in_valid & in_ready;
    assign last = (k == K_LAST);
    assign out_state = st;

    // Per-lane fixed rotation; the window picks which lanes this cycle
    // writes back, so every other lane keeps its current value.
    generate
        for (genvar i = 0; i < 25; i++) begin : g_lane
            localparam int S = RHO[i] % W;
            localparam logic [4:0] LI = 5'(i);
            logic [W-1:0] lane;
            logic [W-1:0] ror;
            logic [W-1:0] rol;
            assign lane = st[W*i +: W];
            // a shift by W yields zero, so S == 0 passes the lane through
            assign ror = (lane >> S) | (lane << (W - S));
            assign rol = (lane << S) | (lane >> (W - S));
            assign rot[i] = dir_q ? rol : ror;
            assign win[i] = (k <= LI) && (LI < k + STEP);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (xfer) state_nx = RUN;
            RUN:  if (last) state_nx = DONE;
            DONE: begin
                if (out_ready) begin
                    state_nx = in_valid ? RUN : IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: in_ready = 1'b1;
            RUN:  busy = 1'b1;
            DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= '0;
            k     <= '0;
            dir_q <= 1'b0;
        end else if (xfer) begin
            st <= in_state;
            k  <= '0;
`ifdef KECCAK_RHO_DIR_SEL_EN
            dir_q <= dir;
`else
            dir_q <= 1'b0;
`endif
        end else if (state == RUN) begin
            for (int i = 0; i < 25; i++) begin
                if (win[i]) st[W*i +: W] <= rot[i];
            end
            k <= k + STEP;
        end
    end

endmodule

// File: tb/tb_keccak_rho_inv.sv
// Self-checking bench for keccak_rho_inv: three instances (LPC 1, 5, 25)
// share stimulus and are checked against a bit-level rho model.
module tb_keccak_rho_inv;

    localparam int W = 64;
    localparam int N = 25 * W;

    localparam int RHO [25] = '{
         0,  1, 62, 28, 27,
        36, 44,  6, 55, 20,
         3, 10, 43, 25, 39,
        41, 45, 15, 21,  8,
        18,  2, 61, 56, 14
    };

    typedef struct {
        logic [N-1:0] s;
        logic [N-1:0] e;
        string        nm;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic [N-1:0] in_state;
    logic         dir;
    logic [N-1:0] os [3];
    logic         ov [3];
    logic         ir [3];
    logic         bz [3];

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    function automatic int lpc_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 5 : 25);
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int LP = (g == 0) ? 1 : ((g == 1) ? 5 : 25);
            keccak_rho_inv #(.W(W), .LPC(LP)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
`ifdef KECCAK_RHO_DIR_SEL_EN
                .dir       (dir),
`endif
                .in_valid  (in_valid),
                .in_ready  (ir[g]),
                .in_state  (in_state),
                .out_valid (ov[g]),
                .out_ready (out_ready),
                .out_state (os[g]),
                .busy      (bz[g])
            );
        end
    endgenerate

    // Reference: bit z of out lane i comes from bit (z + r) mod W of the
    // input lane (inverse), or (z - r) mod W (forward).
    function automatic logic [N-1:0] rho_model(
        input logic [N-1:0] s, input bit fwd);
        logic [N-1:0] o;
        int r, src;
        o = '0;
        for (int i = 0; i < 25; i++) begin
            r = RHO[i] % W;
            for (int z = 0; z < W; z++) begin
                src = fwd ? (z - r + W) % W : (z + r) % W;
                o[W*i + z] = s[W*i + src];
            end
        end
        return o;
    endfunction

    function automatic logic [N-1:0] rand_state();
        logic [N-1:0] s;
        for (int w = 0; w < N / 32; w++) s[32*w +: 32] = $urandom;
        return s;
    endfunction

    task automatic chk(input string nm, input int j,
                       input logic [63:0] got, input logic [63:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s[lpc%0d]: got %h want %h",
                     nm, lpc_of(j), got, want);
        end
    endtask

    task automatic chk_state(input string nm, input int j,
                             input logic [N-1:0] got,
                             input logic [N-1:0] want);
        int bad;
        n_cmp++;
        if (got !== want) begin
            n_err++;
            bad = 0;
            for (int i = 24; i >= 0; i--)
                if (got[W*i +: W] !== want[W*i +: W]) bad = i;
            $display("FAIL %s[lpc%0d] lane %0d: got %h want %h",
                     nm, lpc_of(j), bad, got[W*bad +: W],
                     want[W*bad +: W]);
        end
    endtask

    // Called #1 after the accept edge; counts edges until each out_valid.
    task automatic wait_check(input logic [N-1:0] e, input string nm);
        int lat [3];
        bit all;
        for (int j = 0; j < 3; j++) lat[j] = ov[j] ? 99 : 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            all = 1'b1;
            for (int j = 0; j < 3; j++) begin
                if (ov[j] && lat[j] == 0) lat[j] = c;
                if (lat[j] == 0) all = 1'b0;
            end
            if (all) break;
        end
        for (int j = 0; j < 3; j++) begin
            chk({nm, "_latency"}, j, 64'(lat[j]), 64'(25 / lpc_of(j)));
            chk_state(nm, j, os[j], e);
        end
    endtask

    task automatic load_check(input logic [N-1:0] s,
                              input logic [N-1:0] e, input string nm);
        in_state = s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_check(e, nm);
    endtask

    task automatic release_out(input string nm);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk({nm, "_ov_after"}, j, 64'(ov[j]), 64'd0);
            chk({nm, "_ir_after"}, j, 64'(ir[j]), 64'd1);
        end
    endtask

    vec_t         tbl [4];
    logic [N-1:0] rs;
    logic [N-1:0] rs2;
    logic [N-1:0] fw;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        dir       = 1'b0;

        tbl[0].nm = "lane1_one";
        tbl[0].s = '0;
        tbl[0].s[W*1 +: W] = 64'h1;
        tbl[0].e = '0;
        tbl[0].e[W*1 +: W] = 64'h8000000000000000;

        tbl[1].nm = "lane2_24";
        tbl[1].s = '0;
        tbl[1].s[W*0 +: W]  = 64'hDEADBEEFCAFEF00D;
        tbl[1].s[W*2 +: W]  = 64'h1;
        tbl[1].s[W*24 +: W] = 64'h1;
        tbl[1].e = '0;
        tbl[1].e[W*0 +: W]  = 64'hDEADBEEFCAFEF00D;
        tbl[1].e[W*2 +: W]  = 64'h0000000000000004;
        tbl[1].e[W*24 +: W] = 64'h0004000000000000;

        for (int t = 2; t < 4; t++) begin
            tbl[t].nm = (t == 2) ? "rand_a" : "rand_b";
            tbl[t].s = rand_state();
            tbl[t].e = rho_model(tbl[t].s, 1'b0);
        end

        repeat (2) @(posedge clk);
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("rst_ir", j, 64'(ir[j]), 64'd1);
            chk("rst_ov", j, 64'(ov[j]), 64'd0);
            chk("rst_busy", j, 64'(bz[j]), 64'd0);
            chk_state("rst_out", j, os[j], '0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 4; t++) begin
            load_check(tbl[t].s, tbl[t].e, tbl[t].nm);
            release_out(tbl[t].nm);
        end

        for (int t = 0; t < 6; t++) begin
            rs = rand_state();
            load_check(rs, rho_model(rs, 1'b0), "rand_loop");
            release_out("rand_loop");
        end

        // Hold in DONE with out_ready low while the input wiggles.
        rs = rand_state();
        load_check(rs, rho_model(rs, 1'b0), "hold_load");
        for (int c = 0; c < 10; c++) begin
            in_state = rand_state();
            in_valid = c[0];
            @(posedge clk); #1;
            for (int j = 0; j < 3; j++) begin
                chk_state("hold_out", j, os[j], rho_model(rs, 1'b0));
                chk("hold_ov", j, 64'(ov[j]), 64'd1);
                chk("hold_ir", j, 64'(ir[j]), 64'd0);
            end
        end
        rs2 = rand_state();
        in_state  = rs2;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int j = 0; j < 3; j++)
            chk("b2b_ir", j, 64'(ir[j]), 64'd1);
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            chk("b2b_busy", j, 64'(bz[j]), 64'd1);
            chk("b2b_ov", j, 64'(ov[j]), 64'd0);
        end
        wait_check(rho_model(rs2, 1'b0), "b2b");
        release_out("b2b");

        // Reset after 12 RUN edges (k = 12 on the LPC=1 instance).
        in_state = tbl[2].s;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        chk("mid_busy", 0, 64'(bz[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        for (int j = 0; j < 3; j++) begin
            chk("mrst_ov", j, 64'(ov[j]), 64'd0);
            chk("mrst_busy", j, 64'(bz[j]), 64'd0);
            chk_state("mrst_out", j, os[j], '0);
        end
        @(posedge clk); #1;
        for (int j = 0; j < 3; j++) begin
            chk("mrst_ir", j, 64'(ir[j]), 64'd1);
            chk_state("mrst_out2", j, os[j], '0);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        load_check(tbl[3].s, tbl[3].e, "post_rst");
        release_out("post_rst");

`ifdef KECCAK_RHO_DIR_SEL_EN
        rs = rand_state();
        fw = rho_model(rs, 1'b1);
        dir = 1'b1;
        load_check(rs, fw, "fwd_rand");
        release_out("fwd_rand");
        dir = 1'b0;
        load_check(fw, rs, "inv_back");
        release_out("inv_back");
        rs = '0;
        rs[W*1 +: W] = 64'h1;
        fw = '0;
        fw[W*1 +: W] = 64'h2;
        dir = 1'b1;
        load_check(rs, fw, "fwd_lane1");
        release_out("fwd_lane1");
        dir = 1'b0;
`else
        fw = '0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
